// File: rtl/mqueue_slot_arbiter.sv
// Round-robin arbiter for the shared HMQ outgoing slot. It sequences each message
// through claim, data writes and then commit or discard, with word-limit and inactivity guards.
module mqueue_slot_arbiter #(
  parameter int unsigned g_num_requesters = 4,
  parameter int unsigned g_max_words      = 128,
  parameter int unsigned g_timeout        = 1024
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_i,
  input  logic [g_num_requesters-1:0]           req_i,
  input  logic [g_num_requesters-1:0]           wr_i,
  input  logic [g_num_requesters-1:0]           commit_i,
  input  logic [g_num_requesters-1:0]           discard_i,
  input  logic                                  slot_full_i,
  output logic [g_num_requesters-1:0]           grant_o,
  output logic [$clog2(g_num_requesters)-1:0]   owner_o,
  output logic                                  busy_o,
  output logic                                  mq_claim_o,
  output logic                                  mq_wr_o,
  output logic                                  mq_commit_o,
  output logic                                  mq_discard_o,
  output logic                                  err_overflow_o,
  output logic                                  err_timeout_o,
  output logic [$clog2(g_max_words+1)-1:0]      word_count_o
);

  localparam int unsigned N  = g_num_requesters;
  localparam int unsigned OW = $clog2(g_num_requesters);
  localparam int unsigned CW = $clog2(g_max_words + 1);
  localparam int unsigned TW = $clog2(g_timeout);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLAIM,
    ST_OWNED,
    ST_CLOSE
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            claim_q, claim_d;
  logic            commit_q, commit_d;
  logic            discard_q, discard_d;
  logic            ovf_q, ovf_d;
  logic            tmo_err_q, tmo_err_d;

  logic            owned;
  logic            wr_own;
  logic            commit_own;
  logic            discard_own;
  logic            ovf_hit;
  logic            wr_fwd;
  logic            found;

  assign owned       = (state_q == ST_OWNED);
  assign wr_own      = wr_i[owner_q];
  assign commit_own  = commit_i[owner_q];
  assign discard_own = discard_i[owner_q];
  assign ovf_hit     = wr_own && (count_q == CW'(g_max_words));
  assign wr_fwd      = owned && wr_own && !ovf_hit;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    count_d   = count_q;
    tmo_d     = tmo_q;
    claim_d   = 1'b0;
    commit_d  = 1'b0;
    discard_d = 1'b0;
    ovf_d     = 1'b0;
    tmo_err_d = 1'b0;
    found     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((|req_i) && !slot_full_i) begin
          for (int unsigned i = 1; i <= N; i++) begin
            if (!found && req_i[OW'((32'(last_q) + i) % N)]) begin
              found   = 1'b1;
              owner_d = OW'((32'(last_q) + i) % N);
            end
          end
          // Counters are cleared on entry so word_count_o already reads 0 during CLAIM.
          count_d = '0;
          tmo_d   = '0;
          claim_d = 1'b1;
          state_d = ST_CLAIM;
        end
      end

      ST_CLAIM: begin
        state_d = ST_OWNED;
      end

      ST_OWNED: begin
        if (wr_fwd) begin
          count_d = count_q + CW'(1);
          tmo_d   = '0;
        end else begin
          tmo_d   = tmo_q + TW'(1);
        end

        // The timeout fires on the idle cycle that brings the counter to g_timeout-1.
        if (discard_own) begin
          discard_d = 1'b1;
          state_d   = ST_CLOSE;
        end else if (ovf_hit) begin
          discard_d = 1'b1;
          ovf_d     = 1'b1;
          state_d   = ST_CLOSE;
        end else if (commit_own) begin
          commit_d  = 1'b1;
          state_d   = ST_CLOSE;
        end else if (!wr_own && (tmo_q == TW'(g_timeout - 2))) begin
          discard_d = 1'b1;
          tmo_err_d = 1'b1;
          state_d   = ST_CLOSE;
        end
      end

      ST_CLOSE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= OW'(N - 1);
      count_q   <= '0;
      tmo_q     <= '0;
      claim_q   <= 1'b0;
      commit_q  <= 1'b0;
      discard_q <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      claim_q   <= claim_d;
      commit_q  <= commit_d;
      discard_q <= discard_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign grant_o        = owned ? (N'(1) << owner_q) : '0;
  assign owner_o        = owner_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign mq_claim_o     = claim_q;
  assign mq_wr_o        = wr_fwd;
  assign mq_commit_o    = commit_q;
  assign mq_discard_o   = discard_q;
  assign err_overflow_o = ovf_q;
  assign err_timeout_o  = tmo_err_q;
  assign word_count_o   = count_q;

endmodule

// File: tb/tb_mqueue_slot_arbiter.sv
// Bench for mqueue_slot_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mqueue_slot_arbiter;

  localparam int N    = 4;
  localparam int MAXW = 4;
  localparam int TMO  = 16;

  logic       clk_sys = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] req     = '0;
  logic [3:0] wr      = '0;
  logic [3:0] commit  = '0;
  logic [3:0] discard = '0;
  logic       full    = 1'b0;

  logic [3:0] grant_o;
  logic [1:0] owner_o;
  logic       busy_o, mq_claim_o, mq_wr_o, mq_commit_o, mq_discard_o;
  logic       err_overflow_o, err_timeout_o;
  logic [2:0] word_count_o;

  mqueue_slot_arbiter #(
    .g_num_requesters(N),
    .g_max_words(MAXW),
    .g_timeout(TMO)
  ) dut (
    .clk_sys_i(clk_sys),
    .rst_i(rst),
    .req_i(req),
    .wr_i(wr),
    .commit_i(commit),
    .discard_i(discard),
    .slot_full_i(full),
    .grant_o(grant_o),
    .owner_o(owner_o),
    .busy_o(busy_o),
    .mq_claim_o(mq_claim_o),
    .mq_wr_o(mq_wr_o),
    .mq_commit_o(mq_commit_o),
    .mq_discard_o(mq_discard_o),
    .err_overflow_o(err_overflow_o),
    .err_timeout_o(err_timeout_o),
    .word_count_o(word_count_o)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: which core holds the slot, where the message is in
  // its life (0 free, 1 claiming, 2 held, 3 closing), words accepted and the cycle of
  // the last activity that restarts the inactivity window.
  int m_stage, m_own, m_last, m_words, m_ref, m_cyc;
  bit p_commit, p_discard, p_ovf, p_tmo;

  task automatic model_reset();
    m_stage = 0; m_own = 0; m_last = N - 1; m_words = 0; m_ref = 0;
    p_commit = 0; p_discard = 0; p_ovf = 0; p_tmo = 0;
  endtask

  task automatic model_step();
    bit e_wr, w, hit;
    int c;
    e_wr = (m_stage == 2) && wr[m_own] && (m_words < MAXW);
    chk("grant", grant_o, (m_stage == 2) ? (32'd1 << m_own) : 32'd0);
    chk("owner", owner_o, m_own);
    chk("busy", busy_o, m_stage != 0);
    chk("claim", mq_claim_o, m_stage == 1);
    chk("mq_wr", mq_wr_o, e_wr);
    chk("commit", mq_commit_o, p_commit);
    chk("discard", mq_discard_o, p_discard);
    chk("overflow", err_overflow_o, p_ovf);
    chk("timeout", err_timeout_o, p_tmo);
    chk("word_count", word_count_o, m_words);
    p_commit = 0; p_discard = 0; p_ovf = 0; p_tmo = 0;
    case (m_stage)
      0: if (req != 0 && !full) begin
        hit = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!hit && req[c]) begin hit = 1; m_own = c; end
        end
        m_words = 0;
        m_stage = 1;
      end
      1: begin m_ref = m_cyc; m_stage = 2; end
      2: begin
        w = wr[m_own];
        if (discard[m_own]) begin p_discard = 1; m_stage = 3; end
        else if (w && m_words == MAXW) begin p_discard = 1; p_ovf = 1; m_stage = 3; end
        else if (commit[m_own]) begin p_commit = 1; m_stage = 3; end
        else if (!w && (m_cyc - m_ref) == TMO - 1) begin p_discard = 1; p_tmo = 1; m_stage = 3; end
        if (e_wr) begin m_words++; m_ref = m_cyc; end
      end
      default: begin m_last = m_own; m_stage = 0; end
    endcase
  endtask

  initial begin
    model_reset();
    m_cyc = 0;
    forever begin
      @(negedge clk_sys);
      if (rst) model_reset();
      else model_step();
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int oh2idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic wait_grant(output int own);
    own = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant_o != 0) begin own = oh2idx(grant_o); break; end
    end
    if (own < 0) chk("wait_grant_bound", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; wr = '0; commit = '0; discard = '0; full = 1'b0;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_pulses", {mq_claim_o, mq_wr_o, mq_commit_o, mq_discard_o, err_overflow_o, err_timeout_o}, 0);
    chk("rst_wcount", word_count_o, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  int own, nwr, w, d, seen;
  int seq[5];

  initial begin
    #1 do_reset();

    // single core, three words, commit
    req = 4'b0001; tick();
    chk("t1_claim", mq_claim_o, 1);
    chk("t1_owner", owner_o, 0);
    req = '0; tick();
    chk("t1_grant", grant_o, 4'b0001);
    nwr = 0;
    repeat (3) begin wr = 4'b0001; #1; nwr += int'(mq_wr_o); tick(); end
    wr = '0; commit = 4'b0001; #1;
    chk("t1_nwr", nwr, 3);
    chk("t1_wcount", word_count_o, 3);
    tick(); commit = '0;
    chk("t1_commit", mq_commit_o, 1);
    chk("t1_nodiscard", mq_discard_o, 0);
    tick();
    chk("t1_busy_drop", busy_o, 0);

    // round robin with all cores requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(own);
      seq[k] = own;
      wr = grant_o; tick();
      wr = '0; commit = grant_o; tick();
      commit = '0;
    end
    req = '0;
    chk("t2_seq", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0], seq[4][3:0]}, 20'h01230);

    // overflow on the fifth word
    do_reset();
    req = 4'b0100; wait_grant(own);
    chk("t3_owner", own, 2);
    req = '0; nwr = 0;
    repeat (5) begin wr = 4'b0100; #1; nwr += int'(mq_wr_o); tick(); end
    wr = '0;
    chk("t3_nwr", nwr, 4);
    chk("t3_discard", mq_discard_o, 1);
    chk("t3_ovf", err_overflow_o, 1);
    chk("t3_nocommit", mq_commit_o, 0);
    chk("t3_wcount", word_count_o, 4);
    tick();

    // inactivity timeout, then hand-over to the waiting core
    do_reset();
    req = 4'b1001; wait_grant(own);
    chk("t4_owner0", own, 0);
    req = 4'b1000; wr = 4'b0001; w = cyc; tick();
    wr = '0; seen = 0; d = 0;
    for (int j = 0; j < 40; j++) begin
      if (err_timeout_o) begin seen = 1; d = cyc - w; break; end
      tick();
    end
    chk("t4_seen", seen, 1);
    chk("t4_delay", d, 16);
    chk("t4_discard", mq_discard_o, 1);
    wait_grant(own);
    chk("t4_owner3", own, 3);
    commit = 4'b1000; tick();
    commit = '0; req = '0; tick();

    // backpressure and non-owner strobe filtering, empty commit
    do_reset();
    full = 1'b1; req = 4'b0010;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t5_noclaim", mq_claim_o, 0);
      chk("t5_idle", busy_o, 0);
    end
    full = 1'b0; tick();
    chk("t5_claim", mq_claim_o, 1);
    chk("t5_owner", owner_o, 1);
    tick();
    commit = 4'b0001; discard = 4'b1100; tick();
    chk("t5_held", grant_o, 4'b0010);
    chk("t5_ignored", {mq_commit_o, mq_discard_o}, 0);
    commit = 4'b0010; discard = '0; tick();
    chk("t5_commit", mq_commit_o, 1);
    chk("t5_empty", word_count_o, 0);
    commit = '0; req = '0; tick();

    // asynchronous reset in the middle of a message
    do_reset();
    req = 4'b0100; wait_grant(own);
    req = '0; wr = 4'b0100; tick(); tick();
    wr = '0;
    chk("t6_wcount", word_count_o, 2);
    #2 rst = 1'b1; #1;
    chk("t6_grant", grant_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_pulses", {mq_claim_o, mq_wr_o, mq_commit_o, mq_discard_o, err_overflow_o, err_timeout_o}, 0);
    chk("t6_wcount0", word_count_o, 0);
    tick();
    rst = 1'b0; req = 4'b1111;
    wait_grant(own);
    chk("t6_first", own, 0);
    commit = 4'b0001; tick();
    commit = '0; req = '0; tick();

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      bit quiet;
      quiet = ((i / 150) % 4) == 3;
      for (int b = 0; b < 4; b++) begin
        req[b]     = ($urandom_range(0, 99) < 50);
        wr[b]      = !quiet && ($urandom_range(0, 99) < 40);
        commit[b]  = !quiet && ($urandom_range(0, 99) < 8);
        discard[b] = !quiet && ($urandom_range(0, 99) < 4);
      end
      full = ($urandom_range(0, 99) < 15);
      tick();
    end
    req = '0; wr = '0; commit = '0; discard = '0; full = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

endmodule
